conv_relu_pool: RTL and testbench

- Downstream stage of the 4-kernel convolution block.
- Consumes the four independent per-kernel convolution result streams (conv_dout1..4 / conv_ovalid1..4) and applies optional ReLU, then 2x2 stride-2 max pooling per channel.
- Emits four pooled streams plus a per-frame done pulse to the next layer or the output collector.

---
 rtl/conv_relu_pool.sv | 149 ++++++++++++++
 tb/tb_conv_relu_pool.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_relu_pool.sv
// Per-channel optional ReLU + 2x2 stride-2 max pooling for four skewed conv streams.
// Define POOL_RELU_EN to clamp negative input samples to zero before pooling.
module conv_relu_pool #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned FMAP_COL   = 5,
    parameter int unsigned FMAP_ROW   = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] conv_dout1,
    input  logic [DATA_WIDTH-1:0] conv_dout2,
    input  logic [DATA_WIDTH-1:0] conv_dout3,
    input  logic [DATA_WIDTH-1:0] conv_dout4,
    input  logic                  conv_ovalid1,
    input  logic                  conv_ovalid2,
    input  logic                  conv_ovalid3,
    input  logic                  conv_ovalid4,
    output logic [DATA_WIDTH-1:0] pool_dout1,
    output logic [DATA_WIDTH-1:0] pool_dout2,
    output logic [DATA_WIDTH-1:0] pool_dout3,
    output logic [DATA_WIDTH-1:0] pool_dout4,
    output logic                  pool_ovalid1,
    output logic                  pool_ovalid2,
    output logic                  pool_ovalid3,
    output logic                  pool_ovalid4,
    output logic                  pool_done
);

    localparam int unsigned NCH   = 4;
    localparam int unsigned PC    = FMAP_COL / 2;
    localparam int unsigned PR    = FMAP_ROW / 2;
    localparam int unsigned COL_W = (FMAP_COL > 1) ? $clog2(FMAP_COL) : 1;
    localparam int unsigned ROW_W = (FMAP_ROW > 1) ? $clog2(FMAP_ROW) : 1;
    localparam int unsigned IDX_W = (PC > 1) ? $clog2(PC) : 1;

    logic [DATA_WIDTH-1:0] din      [NCH];
    logic [NCH-1:0]        vin;
    logic [DATA_WIDTH-1:0] dout_arr [NCH];
    logic [NCH-1:0]        ovalid_arr;
    logic [NCH-1:0]        wrap_c;
    logic [NCH-1:0]        flag_q;
    logic [NCH-1:0]        flag_nxt_c;

    assign din[0] = conv_dout1;
    assign din[1] = conv_dout2;
    assign din[2] = conv_dout3;
    assign din[3] = conv_dout4;
    assign vin    = {conv_ovalid4, conv_ovalid3, conv_ovalid2, conv_ovalid1};

    assign pool_dout1   = dout_arr[0];
    assign pool_dout2   = dout_arr[1];
    assign pool_dout3   = dout_arr[2];
    assign pool_dout4   = dout_arr[3];
    assign pool_ovalid1 = ovalid_arr[0];
    assign pool_ovalid2 = ovalid_arr[1];
    assign pool_ovalid3 = ovalid_arr[2];
    assign pool_ovalid4 = ovalid_arr[3];

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        logic signed [DATA_WIDTH-1:0] samp;
        logic signed [DATA_WIDTH-1:0] h_reg;
        logic signed [DATA_WIDTH-1:0] hmax;
        logic signed [DATA_WIDTH-1:0] result;
        logic signed [DATA_WIDTH-1:0] line_buf [PC];
        logic        [DATA_WIDTH-1:0] dout_r;
        logic                         ovalid_r;
        logic        [COL_W-1:0]      col_cnt;
        logic        [ROW_W-1:0]      row_cnt;
        logic        [IDX_W-1:0]      lb_idx;
        logic                         col_last;
        logic                         row_last;
        logic                         col_in;
        logic                         row_in;
        logic                         wr_line;
        logic                         emit;

        // Input clamp, horizontal max and vertical max against the stored row.
        always_comb begin
`ifdef POOL_RELU_EN
            samp = din[g][DATA_WIDTH-1] ? '0 : $signed(din[g]);
`else
            samp = $signed(din[g]);
`endif
            hmax     = (samp > h_reg) ? samp : h_reg;
            lb_idx   = IDX_W'(col_cnt >> 1);
            result   = (hmax > line_buf[lb_idx]) ? hmax : line_buf[lb_idx];
            col_last = (col_cnt == COL_W'(FMAP_COL - 1));
            row_last = (row_cnt == ROW_W'(FMAP_ROW - 1));
            // Trailing odd column/row fall outside every 2x2 window.
            col_in   = (32'(col_cnt) < 2 * PC);
            row_in   = (32'(row_cnt) < 2 * PR);
            wr_line  = vin[g] && col_cnt[0] && col_in && !row_cnt[0] && row_in;
            emit     = vin[g] && col_cnt[0] && col_in && row_cnt[0] && row_in;
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                col_cnt  <= '0;
                row_cnt  <= '0;
                h_reg    <= '0;
                dout_r   <= '0;
                ovalid_r <= 1'b0;
                for (int i = 0; i < int'(PC); i++) begin
                    line_buf[i] <= '0;
                end
            end else begin
                ovalid_r <= emit;
                if (emit) begin
                    dout_r <= result;
                end
                if (wr_line) begin
                    line_buf[lb_idx] <= hmax;
                end
                if (vin[g]) begin
                    if (!col_cnt[0]) begin
                        h_reg <= samp;
                    end
                    if (col_last) begin
                        col_cnt <= '0;
                        row_cnt <= row_last ? '0 : row_cnt + 1'b1;
                    end else begin
                        col_cnt <= col_cnt + 1'b1;
                    end
                end
            end
        end

        assign wrap_c[g]     = vin[g] && col_last && row_last;
        assign dout_arr[g]   = dout_r;
        assign ovalid_arr[g] = ovalid_r;
    end

    // Sticky per-channel frame flags; wraps arriving this cycle count toward the pulse.
    assign flag_nxt_c = flag_q | wrap_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            flag_q    <= '0;
            pool_done <= 1'b0;
        end else if (&flag_nxt_c) begin
            flag_q    <= '0;
            pool_done <= 1'b1;
        end else begin
            flag_q    <= flag_nxt_c;
            pool_done <= 1'b0;
        end
    end

endmodule

// File: tb/tb_conv_relu_pool.sv
// Directed bench for conv_relu_pool on a 5x5 map: values, output latency and pool_done timing.
module tb_conv_relu_pool;

    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] d  [4];
    logic [3:0]    v;
    logic [DW-1:0] po [4];
    logic [3:0]    pv;
    logic          done;

    always #5 clk = ~clk;

    conv_relu_pool #(.DATA_WIDTH(DW), .FMAP_COL(5), .FMAP_ROW(5)) dut (
        .clk(clk), .rst(rst),
        .conv_dout1(d[0]), .conv_dout2(d[1]), .conv_dout3(d[2]), .conv_dout4(d[3]),
        .conv_ovalid1(v[0]), .conv_ovalid2(v[1]), .conv_ovalid3(v[2]), .conv_ovalid4(v[3]),
        .pool_dout1(po[0]), .pool_dout2(po[1]), .pool_dout3(po[2]), .pool_dout4(po[3]),
        .pool_ovalid1(pv[0]), .pool_ovalid2(pv[1]), .pool_ovalid3(pv[2]), .pool_ovalid4(pv[3]),
        .pool_done(done)
    );

    int            total = 0;
    int            bad   = 0;
    int            ncyc  = 0;
    logic [DW-1:0] stim  [4][$];
    int            start [4];
    bit            gap   [4];
    int            fidx  [4];
    int            acc_t [4][$];
    int            last_t[4][$];
    logic [DW-1:0] out_v [4][$];
    int            out_t [4][$];
    int            done_cnt = 0;
    int            done_t[$];

    always @(posedge clk) ncyc++;

    // Output log: value and cycle of every pooled sample and done pulse.
    always @(negedge clk) begin
        for (int c = 0; c < 4; c++) begin
            if (pv[c]) begin
                out_v[c].push_back(po[c]);
                out_t[c].push_back(ncyc);
            end
        end
        if (done) begin
            done_cnt++;
            done_t.push_back(ncyc);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        for (int c = 0; c < 4; c++) begin
            stim[c].delete();
            acc_t[c].delete();
            last_t[c].delete();
            out_v[c].delete();
            out_t[c].delete();
            start[c] = 0;
            gap[c]   = 1'b0;
            fidx[c]  = 0;
        end
        done_cnt = 0;
        done_t.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        v   = '0;
    endtask

    task automatic load(input int c, input int base, input int n);
        for (int i = 0; i < n; i++) stim[c].push_back(DW'(base + i));
    endtask

    // Drives every channel's queue, honouring start offset and optional random gaps.
    task automatic feed(input int max_cyc);
        int k;
        int left;
        k = 0;
        left = 1;
        while (left > 0 && k < max_cyc) begin
            @(negedge clk);
            left = 0;
            for (int c = 0; c < 4; c++) begin
                v[c] = 1'b0;
                if (stim[c].size() > 0) begin
                    if (k >= start[c] && (!gap[c] || $urandom_range(0, 1) == 1)) begin
                        d[c] = stim[c].pop_front();
                        v[c] = 1'b1;
                        if (fidx[c] inside {6, 8, 16, 18}) acc_t[c].push_back(ncyc);
                        if (fidx[c] == 24) last_t[c].push_back(ncyc);
                        fidx[c] = (fidx[c] == 24) ? 0 : fidx[c] + 1;
                    end
                    left += stim[c].size();
                end
            end
            k++;
        end
        @(negedge clk);
        v = '0;
        chk("feed_budget", left, 0);
        repeat (4) @(negedge clk);
    endtask

    // Expects nfr frames of raster data with base f*100 on channel c, each 1 cycle after its window closes.
    task automatic check_ch(input int c, input int nfr);
        int e[4];
        int n;
        e = '{6, 8, 16, 18};
        n = 4 * nfr;
        chk($sformatf("ch%0d_count", c + 1), out_v[c].size(), n);
        if (out_v[c].size() == n && acc_t[c].size() == n) begin
            for (int i = 0; i < n; i++) begin
                chk($sformatf("ch%0d_val%0d", c + 1, i), out_v[c][i], DW'((i / 4) * 100 + e[i % 4]));
                chk($sformatf("ch%0d_lat%0d", c + 1, i), out_t[c][i], acc_t[c][i] + 1);
            end
        end
    endtask

    initial begin
        logic [DW-1:0] neg5;
        logic [DW-1:0] exp_neg;
        logic [DW-1:0] exp_m100;
        neg5 = 16'hFFFB;
`ifdef POOL_RELU_EN
        exp_neg  = 16'h0000;
        exp_m100 = 16'h0000;
`else
        exp_neg  = 16'hFFFB;
        exp_m100 = 16'hFF9C;
`endif
        rst = 1'b1;
        v   = '0;
        for (int c = 0; c < 4; c++) d[c] = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Reset state.
        for (int c = 0; c < 4; c++) begin
            chk($sformatf("rst_dout%0d", c + 1), po[c], 0);
        end
        chk("rst_ovalid", pv, 0);
        chk("rst_done", done, 0);

        // Channel 1 alone, continuous.
        clear_logs();
        load(0, 0, 25);
        feed(200);
        check_ch(0, 1);
        chk("t1_ch2_idle", out_v[1].size() + out_v[2].size() + out_v[3].size(), 0);
        chk("t1_no_done", done_cnt, 0);

        // All channels, channel k delayed by 3k cycles.
        do_reset();
        clear_logs();
        for (int c = 0; c < 4; c++) begin
            load(c, 0, 25);
            start[c] = (c + 1) * 3;
        end
        feed(200);
        for (int c = 0; c < 4; c++) check_ch(c, 1);
        chk("t2_done_cnt", done_cnt, 1);
        if (done_t.size() == 1 && last_t[3].size() == 1)
            chk("t2_done_time", done_t[0], last_t[3][0] + 1);

        // Channel 2 negative frame, then a frame holding the mixed-sign window.
        do_reset();
        clear_logs();
        for (int i = 0; i < 25; i++) stim[1].push_back(neg5);
        for (int i = 0; i < 25; i++) begin
            case (i)
                0:       stim[1].push_back(16'hFFFD);
                1:       stim[1].push_back(16'h0007);
                5:       stim[1].push_back(16'h8000);
                6:       stim[1].push_back(16'h0002);
                default: stim[1].push_back(16'hFF9C);
            endcase
        end
        feed(200);
        chk("t3_count", out_v[1].size(), 8);
        if (out_v[1].size() == 8) begin
            for (int i = 0; i < 4; i++) chk($sformatf("t3_neg%0d", i), out_v[1][i], exp_neg);
            chk("t3_mixed_window", out_v[1][4], 16'h0007);
            for (int i = 5; i < 8; i++) chk($sformatf("t3_m100_%0d", i), out_v[1][i], exp_m100);
        end

        // Channel 3 with random gaps in valid.
        do_reset();
        clear_logs();
        load(2, 0, 25);
        gap[2] = 1'b1;
        feed(400);
        check_ch(2, 1);

        // Reset mid-frame on channel 1, with a valid sample during the reset cycle.
        do_reset();
        clear_logs();
        load(0, 0, 12);
        feed(100);
        chk("t5_pre_count", out_v[0].size(), 2);
        clear_logs();
        @(negedge clk);
        rst  = 1'b1;
        v[0] = 1'b1;
        d[0] = 16'd99;
        @(negedge clk);
        rst = 1'b0;
        v   = '0;
        chk("t5_rst_ovalid", pv, 0);
        chk("t5_rst_dout1", po[0], 0);
        load(0, 0, 25);
        feed(200);
        check_ch(0, 1);
        chk("t5_no_done", done_cnt, 0);

        // Two back-to-back frames on all skewed channels.
        do_reset();
        clear_logs();
        for (int c = 0; c < 4; c++) begin
            load(c, 0, 25);
            load(c, 100, 25);
            start[c] = c * 3;
        end
        feed(300);
        for (int c = 0; c < 4; c++) check_ch(c, 2);
        chk("t6_done_cnt", done_cnt, 2);
        if (done_t.size() == 2 && last_t[3].size() == 2) begin
            chk("t6_done_time0", done_t[0], last_t[3][0] + 1);
            chk("t6_done_time1", done_t[1], last_t[3][1] + 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
